// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared types and helpers for the LCD write-engine arbiter family.
package lcd_arb_pkg;

  // Arbiter FSM state encodings.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE,
    S_ABORT = ST_ABORT
  } state_t;

  // LCD register select values.
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Ceiling log2, never below 1 so a counter or index is at least one bit wide.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v / 2;
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester and engine handshake bundle around the LCD bus arbiter.
// master: the arbiter's view; slave: the requesters/engine side.
interface lcd_bus_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    req_rs;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               err;
  logic               busy;
  logic               eng_start;
  logic               eng_rs;
  logic [DW-1:0]      eng_data;
  logic               eng_ready;
  logic               eng_cycend;

  modport master (
    input  req, req_lock, req_rs, req_data, eng_ready, eng_cycend,
    output gnt, done, err, busy, eng_start, eng_rs, eng_data
  );

  modport slave (
    output req, req_lock, req_rs, req_data, eng_ready, eng_cycend,
    input  gnt, done, err, busy, eng_start, eng_rs, eng_data
  );
endinterface

// File: rtl/lcd_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request starting at ptr, wrapping.
module rr_pick
  import lcd_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx
);

  // Scan offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    any = 1'b0;
    idx = {PW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      any = req[(int'(ptr) + i) % NREQ] ? 1'b1 : any;
      idx = req[(int'(ptr) + i) % NREQ] ? PW'((int'(ptr) + i) % NREQ) : idx;
    end
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one LCD write engine between NREQ requesters: round-robin grant,
// optional lock for multi-byte sequences, watchdog abort on a stuck engine.
// All outputs are registered decodes of the next state.
module lcd_bus_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = 8,
  parameter int TOUT = 1023
) (
  input logic               clk,
  input logic               rst,
  lcd_bus_arbiter_if.master bus
);

  localparam int PW = clog2(NREQ);
  localparam int WW = clog2(TOUT + 1);

  state_t          state_r, state_s;
  logic [PW-1:0]   owner_r, owner_s;
  logic [PW-1:0]   ptr_r, ptr_s;
  logic [PW-1:0]   owner_next_s;
  logic [PW-1:0]   pick_idx_s;
  logic            pick_any_s;
  logic [WW-1:0]   wdog_r, wdog_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [NREQ-1:0] done_r, done_s;
  logic            err_r, err_s;
  logic            busy_r, busy_s;
  logic            start_r, start_s;
  logic            rs_r, rs_s;
  logic [DW-1:0]   data_r, data_s;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (bus.req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  assign owner_next_s = (owner_r == PW'(NREQ - 1)) ? {PW{1'b0}} : owner_r + PW'(1'b1);

  // Next-state, bookkeeping and next-output decode.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    wdog_s  = wdog_r;
    rs_s    = rs_r;
    data_s  = data_r;
    gnt_s   = {NREQ{1'b0}};
    done_s  = {NREQ{1'b0}};
    err_s   = 1'b0;
    start_s = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (bus.eng_ready && pick_any_s) begin
          owner_s = pick_idx_s;
          rs_s    = bus.req_rs[pick_idx_s];
          data_s  = bus.req_data[int'(pick_idx_s) * DW +: DW];
          state_s = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        wdog_s  = {WW{1'b0}};
        state_s = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats a coincident timeout.
        if (bus.eng_cycend) begin
          state_s = S_DONE;
        end else if (wdog_r == WW'(TOUT - 1)) begin
          state_s = S_ABORT;
        end else begin
          wdog_s  = (wdog_r != {WW{1'b1}}) ? wdog_r + WW'(1'b1) : wdog_r;
          state_s = S_WAIT;
        end
      end
      S_DONE: begin
        // Locked owner keeps the engine without re-arbitration.
        if (bus.req_lock[owner_r] && bus.req[owner_r]) begin
          rs_s    = bus.req_rs[owner_r];
          data_s  = bus.req_data[int'(owner_r) * DW +: DW];
          state_s = S_ISSUE;
        end else begin
          ptr_s   = owner_next_s;
          state_s = S_IDLE;
        end
      end
      S_ABORT: begin
        ptr_s   = owner_next_s;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    busy_s = (state_s != S_IDLE);
    case (state_s)
      S_ISSUE: begin
        gnt_s   = {{(NREQ-1){1'b0}}, 1'b1} << owner_s;
        start_s = 1'b1;
      end
      S_WAIT: begin
        gnt_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_s;
      end
      S_DONE: begin
        gnt_s  = {{(NREQ-1){1'b0}}, 1'b1} << owner_s;
        done_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_s;
      end
      S_ABORT: begin
        gnt_s  = {{(NREQ-1){1'b0}}, 1'b1} << owner_s;
        done_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_s;
        err_s  = 1'b1;
      end
      default: begin
        gnt_s = {NREQ{1'b0}};
      end
    endcase
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      owner_r <= {PW{1'b0}};
      ptr_r   <= {PW{1'b0}};
      wdog_r  <= {WW{1'b0}};
      gnt_r   <= {NREQ{1'b0}};
      done_r  <= {NREQ{1'b0}};
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      start_r <= 1'b0;
      rs_r    <= RS_CMD;
      data_r  <= {DW{1'b0}};
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      wdog_r  <= wdog_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      start_r <= start_s;
      rs_r    <= rs_s;
      data_r  <= data_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;
  assign bus.eng_start = start_r;
  assign bus.eng_rs    = rs_r;
  assign bus.eng_data  = data_r;

endmodule
